// File: rtl/tile_dispatch_writer.sv
// Staging-buffer to tile L1 BRAM write producer (broadcast / distribute).
// Optional DISPATCH_LINE_COUNT_EN adds o_wr_line_count.
module tile_dispatch_writer #(
   parameter int NUM_TILES            = 16,
   parameter int TILE_BRAM_ADDR_WIDTH = 9,
   parameter int TILE_BRAM_WIDTH      = 256,
   parameter int SRC_ADDR_WIDTH       = 11
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_disp_en,
   input  logic [SRC_ADDR_WIDTH-1:0]       i_src_addr,
   input  logic [TILE_BRAM_ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [9:0]                      i_num_lines,
   input  logic [9:0]                      i_chunk_lines,
   input  logic                            i_side_right,
   input  logic                            i_distribute,
   input  logic [NUM_TILES-1:0]            i_column_enable,
   input  logic                            i_hold,
   output logic                            o_src_rd_en,
   output logic [SRC_ADDR_WIDTH-1:0]       o_src_rd_addr,
   input  logic [TILE_BRAM_WIDTH-1:0]      i_src_rd_man_data,
   input  logic [7:0]                      i_src_rd_exp_data,
   output logic [NUM_TILES-1:0]            o_wr_en_left,
   output logic [NUM_TILES-1:0]            o_wr_en_right,
   output logic [TILE_BRAM_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [TILE_BRAM_WIDTH-1:0]      o_wr_man_data,
   output logic [7:0]                      o_wr_exp_data,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_err
`ifdef DISPATCH_LINE_COUNT_EN
   ,
   output logic [9:0]                      o_wr_line_count
`endif
);

   localparam int PW = $clog2(NUM_TILES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [SRC_ADDR_WIDTH-1:0]       src_q;
   logic [TILE_BRAM_ADDR_WIDTH-1:0] dst_q;
   logic [9:0]                      num_q;
   logic [9:0]                      chunk_q;
   logic                            side_q;
   logic                            dist_q;
   logic [NUM_TILES-1:0]            mask_q;
   logic [9:0]                      k_q;
   logic [9:0]                      cidx_q;
   logic [PW-1:0]                   ptr_q;
   logic                            err_q;

   logic                            wr_vld_q;
   logic [NUM_TILES-1:0]            wr_en_l_q;
   logic [NUM_TILES-1:0]            wr_en_r_q;
   logic [TILE_BRAM_ADDR_WIDTH-1:0] wr_addr_q;
   logic [TILE_BRAM_WIDTH-1:0]      man_q;
   logic [7:0]                      exp_q;

   logic                            cur_vld;
   logic [PW-1:0]                   cur_tile;
   logic                            accept;
   logic                            bad_cmd;
   logic                            issue;
   logic                            no_tile;
   logic                            last;
   logic                            chunk_end;
   logic [NUM_TILES-1:0]            line_mask;
   logic [TILE_BRAM_ADDR_WIDTH-1:0] line_addr;

   // Lowest enabled tile at or above the pointer.
   always_comb begin
      cur_vld  = 1'b0;
      cur_tile = '0;
      for (int i = NUM_TILES - 1; i >= 0; i--) begin
         if (mask_q[i] && (PW'(i) >= ptr_q)) begin
            cur_vld  = 1'b1;
            cur_tile = PW'(i);
         end
      end
   end

   assign accept    = (state == S_IDLE) && i_disp_en;
   assign bad_cmd   = (i_column_enable == '0) ||
                      (i_distribute && (i_chunk_lines == 10'd0));
   assign issue     = (state == S_RUN) && !i_hold && (!dist_q || cur_vld);
   assign no_tile   = (state == S_RUN) && dist_q && !cur_vld;
   assign last      = issue && ((k_q + 10'd1) == num_q);
   assign chunk_end = (cidx_q + 10'd1) == chunk_q;
   assign line_mask = dist_q ? (NUM_TILES'(1) << cur_tile) : mask_q;
   assign line_addr = dst_q + (dist_q ? TILE_BRAM_ADDR_WIDTH'(cidx_q)
                                      : TILE_BRAM_ADDR_WIDTH'(k_q));

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (i_disp_en) begin
               if ((i_num_lines == 10'd0) || bad_cmd) state_nx = S_DONE;
               else                                   state_nx = S_RUN;
            end
         end
         S_RUN:   if (no_tile || last) state_nx = S_DRAIN;
         S_DRAIN: state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         num_q     <= '0;
         chunk_q   <= '0;
         side_q    <= 1'b0;
         dist_q    <= 1'b0;
         mask_q    <= '0;
         k_q       <= '0;
         cidx_q    <= '0;
         ptr_q     <= '0;
         err_q     <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_en_l_q <= '0;
         wr_en_r_q <= '0;
         wr_addr_q <= '0;
         man_q     <= '0;
         exp_q     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            src_q   <= i_src_addr;
            dst_q   <= i_dst_addr;
            num_q   <= i_num_lines;
            chunk_q <= i_chunk_lines;
            side_q  <= i_side_right;
            dist_q  <= i_distribute;
            mask_q  <= i_column_enable;
            k_q     <= '0;
            cidx_q  <= '0;
            ptr_q   <= '0;
            err_q   <= bad_cmd;
         end else if (i_disp_en || no_tile) begin
            err_q <= 1'b1;
         end
         if (issue) begin
            k_q <= k_q + 10'd1;
            if (chunk_end) begin
               cidx_q <= '0;
               ptr_q  <= cur_tile + PW'(1);
            end else begin
               cidx_q <= cidx_q + 10'd1;
            end
            wr_addr_q <= line_addr;
         end
         wr_vld_q  <= issue;
         wr_en_l_q <= (issue && !side_q) ? line_mask : '0;
         wr_en_r_q <= (issue && side_q) ? line_mask : '0;
         if (wr_vld_q) begin
            man_q <= i_src_rd_man_data;
            exp_q <= i_src_rd_exp_data;
         end
      end
   end

`ifdef DISPATCH_LINE_COUNT_EN
   logic [9:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_reset)       cnt_q <= '0;
      else if (accept)   cnt_q <= '0;
      else if (wr_vld_q) cnt_q <= cnt_q + 10'd1;
   end

   assign o_wr_line_count = cnt_q;
`endif

   // Source data arrives the cycle after the read; forward it on write.
   assign o_src_rd_en   = issue;
   assign o_src_rd_addr = src_q + SRC_ADDR_WIDTH'(k_q);
   assign o_wr_en_left  = wr_en_l_q;
   assign o_wr_en_right = wr_en_r_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_man_data = wr_vld_q ? i_src_rd_man_data : man_q;
   assign o_wr_exp_data = wr_vld_q ? i_src_rd_exp_data : exp_q;
   assign o_busy        = state != S_IDLE;
   assign o_done        = state == S_DONE;
   assign o_err         = err_q;

endmodule
